// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, stall encodings and stall priority function for pipe_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // Bit order: [0]pc [1]if/if_id [2]id/id_ex [3]ex/ex_mem [4]mem/mem_wb [5]wb
    typedef logic [5:0] stall_t;

    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    localparam int STALL_IF_BIT = 1;

    // Flush outranks every stall source so a redirect is never held back.
    function automatic stall_t stall_encode(input state_t st,
                                            input logic   flush_req,
                                            input logic   req_ex,
                                            input logic   req_id);
        if (st == ST_FLUSH || flush_req)
            return STALL_NONE;
        if (st == ST_MC_BUSY || req_ex)
            return STALL_EX;
        if (req_id)
            return STALL_ID;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/response bundle between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) ();

    logic              stallreq_id;
    logic              stallreq_ex;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_cycles;
    logic              flush_req;
    logic [ADDR_W-1:0] flush_pc;

    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              ex_mc_busy;
    logic              ex_mc_done;
    logic              ex_mc_abort;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_abort, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_abort, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// rtl/pipe_ctrl_mc_counter.sv - load/decrement countdown for multi-cycle EX operations
module pipe_ctrl_mc_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with multi-cycle EX sequencing and stall counter
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              latch_pc;
    logic              done_nxt;
    logic              abort_nxt;
    logic              done_q;
    logic              abort_q;
    logic [ADDR_W-1:0] new_pc_q;
    logic [PERF_W-1:0] perf_q;
    stall_t            stall_c;

    // A zero-cycle request still occupies EX for one cycle.
    assign cnt_load_val = (bus.ex_mc_cycles == '0) ? '0 : bus.ex_mc_cycles - CNT_W'(1);

    pipe_ctrl_mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        latch_pc  = 1'b0;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = ST_FLUSH;
                    latch_pc  = 1'b1;
                end else if (bus.ex_mc_start) begin
                    state_nxt = ST_MC_BUSY;
                    cnt_load  = 1'b1;
                end
            end
            ST_MC_BUSY: begin
                if (bus.flush_req) begin
                    state_nxt = ST_FLUSH;
                    latch_pc  = 1'b1;
                    abort_nxt = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_req)
                    latch_pc = 1'b1;
                else
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall_c = rst ? STALL_NONE
                         : stall_encode(state, bus.flush_req, bus.stallreq_ex, bus.stallreq_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            new_pc_q <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            perf_q   <= '0;
        end else begin
            state   <= state_nxt;
            done_q  <= done_nxt;
            abort_q <= abort_nxt;
            if (latch_pc)
                new_pc_q <= bus.flush_pc;
            if (stall_c[STALL_IF_BIT] && perf_q != '1)
                perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = (state == ST_FLUSH);
    assign bus.new_pc       = new_pc_q;
    assign bus.ex_mc_busy   = (state == ST_MC_BUSY);
    assign bus.ex_mc_done   = done_q;
    assign bus.ex_mc_abort  = abort_q;
    assign bus.stall_cycles = perf_q;

    // Starting a new multi-cycle op while one is running is a protocol violation upstream.
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst)
        !(state == ST_MC_BUSY && bus.ex_mc_start));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl built with a 4-bit stall counter
module tb_pipe_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 6;
    localparam int PERF_W = 4;

    typedef struct packed {
        logic              flush;
        logic              done;
        logic              abort;
        logic [ADDR_W-1:0] pc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t               exp_q[$];
    ev_t               mon_e;
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [PERF_W-1:0] sc_model = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic set_in(input logic id, input logic ex, input logic start,
                          input logic [CNT_W-1:0] cyc, input logic freq,
                          input logic [ADDR_W-1:0] pc);
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.ex_mc_start  = start;
        bus.ex_mc_cycles = cyc;
        bus.flush_req    = freq;
        bus.flush_pc     = pc;
    endtask

    task automatic push_ev(input logic f, input logic d, input logic a, input logic [ADDR_W-1:0] pc);
        ev_t e;
        e.flush = f;
        e.done  = d;
        e.abort = a;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // One clock: check the combinational stall mid-cycle, then advance the counter model.
    task automatic cyc(input string tag, input logic [5:0] exp_stall);
        @(negedge clk);
        check({tag, ".stall"}, 64'(bus.stall), 64'(exp_stall));
        check({tag, ".stall_cycles"}, 64'(bus.stall_cycles), 64'(sc_model));
        @(posedge clk);
        if (rst)
            sc_model = '0;
        else if (exp_stall[1] && sc_model != '1)
            sc_model = sc_model + PERF_W'(1);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.flush === 1'b1 || bus.ex_mc_done === 1'b1 || bus.ex_mc_abort === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor.unexpected: got flush=%b done=%b abort=%b pc=%0h want no event",
                         bus.flush, bus.ex_mc_done, bus.ex_mc_abort, bus.new_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.flush !== mon_e.flush || bus.ex_mc_done !== mon_e.done ||
                    bus.ex_mc_abort !== mon_e.abort || (mon_e.flush && bus.new_pc !== mon_e.pc)) begin
                    n_fail++;
                    $display("FAIL monitor.event: got flush=%b done=%b abort=%b pc=%0h want flush=%b done=%b abort=%b pc=%0h",
                             bus.flush, bus.ex_mc_done, bus.ex_mc_abort, bus.new_pc,
                             mon_e.flush, mon_e.done, mon_e.abort, mon_e.pc);
                end
            end
        end
    end

    initial begin
        set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0000_1234);
        @(posedge clk);
        #1;

        // Reset dominates live requests
        cyc("rst", 6'b000000);
        check("rst.flush", 64'(bus.flush), 64'd0);
        check("rst.new_pc", 64'(bus.new_pc), 64'd0);
        check("rst.stall_cycles", 64'(bus.stall_cycles), 64'd0);
        check("rst.busy", 64'(bus.ex_mc_busy), 64'd0);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("idle", 6'b000000);

        // Load-use stall, then EX stall outranking it
        set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc("id", 6'b000111);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("id_end", 6'b000000);
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        cyc("id_ex", 6'b001111);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("id_ex_end", 6'b000000);

        // Five-cycle op, then zero-cycle op treated as one
        set_in(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, '0);
        push_ev(1'b0, 1'b1, 1'b0, '0);
        cyc("mc5_start", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc("mc5_busy", 6'b001111);
        cyc("mc5_done", 6'b000000);
        check("mc5.busy_after", 64'(bus.ex_mc_busy), 64'd0);
        set_in(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, '0);
        push_ev(1'b0, 1'b1, 1'b0, '0);
        cyc("mc0_start", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("mc0_busy", 6'b001111);
        cyc("mc0_done", 6'b000000);

        // Flush kills a running op at cnt=3
        set_in(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, '0);
        cyc("abort_start", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("abort_busy", 6'b001111);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0020);
        push_ev(1'b1, 1'b0, 1'b1, 32'h0000_0020);
        cyc("abort_req", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("abort_flush", 6'b000000);
        check("abort.busy_after", 64'(bus.ex_mc_busy), 64'd0);
        for (int i = 0; i < 3; i++) cyc("abort_idle", 6'b000000);

        // Flush beats a simultaneous start; then back-to-back flushes
        set_in(1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 32'h0000_0100);
        push_ev(1'b1, 1'b0, 1'b0, 32'h0000_0100);
        cyc("fs_req", 6'b000000);
        check("fs.busy_flush", 64'(bus.ex_mc_busy), 64'd0);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("fs_flush", 6'b000000);
        check("fs.busy_idle", 64'(bus.ex_mc_busy), 64'd0);
        cyc("fs_idle", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0040);
        push_ev(1'b1, 1'b0, 1'b0, 32'h0000_0040);
        cyc("ff_req1", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0080);
        push_ev(1'b1, 1'b0, 1'b0, 32'h0000_0080);
        cyc("ff_req2", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("ff_flush", 6'b000000);
        cyc("ff_idle", 6'b000000);
        check("ff.flush_after", 64'(bus.flush), 64'd0);

        // Flush suppresses concurrent stall requests
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0000_0044);
        push_ev(1'b1, 1'b0, 1'b0, 32'h0000_0044);
        cyc("fst_req", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("fst_flush", 6'b000000);
        cyc("fst_idle", 6'b000000);

        // Counter saturation at 4'hF
        set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cyc("sat", 6'b000111);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("sat_end", 6'b000000);
        check("sat.value", 64'(bus.stall_cycles), 64'hF);

        // Reset in the middle of a busy op: no done/abort afterwards
        set_in(1'b0, 1'b0, 1'b1, 6'd10, 1'b0, '0);
        cyc("rb_start", 6'b000000);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cyc("rb_busy", 6'b001111);
        cyc("rb_busy", 6'b001111);
        rst = 1'b1;
        cyc("rb_rst", 6'b000000);
        rst = 1'b0;
        check("rb.busy", 64'(bus.ex_mc_busy), 64'd0);
        check("rb.done", 64'(bus.ex_mc_done), 64'd0);
        check("rb.abort", 64'(bus.ex_mc_abort), 64'd0);
        check("rb.stall_cycles", 64'(bus.stall_cycles), 64'd0);
        for (int i = 0; i < 12; i++) cyc("rb_idle", 6'b000000);

        check("scoreboard.drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
